// File: rtl/stream_decoder.sv
// ---------------------------------------------------------------------------
// stream_decoder
//
// Converts a unipolar stochastic bitstream back into a binary count. After a
// start request the block waits SKIP cycles so upstream generator and neuron
// pipeline registers can flush, then counts the ones present on bit_in over a
// window of 2^WINDOW_BITS cycles. The result is presented on a valid/ready
// handshake and held until the consumer accepts it.
//
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   bit_in     in   stochastic bitstream, one bit per cycle
//   start      in   request a new measurement (accepted in IDLE, or in HOLD
//                   on the handshake edge for back-to-back operation)
//   out_ready  in   consumer accepts value
//   value      out  count of ones in the window, 0 .. 2^WINDOW_BITS
//   out_valid  out  value is valid
//   busy       out  high whenever the decoder is not idle
//
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module stream_decoder #(
   parameter int WINDOW_BITS = 8,
   parameter int SKIP        = 2
) (
   input  logic                   clk,
   input  logic                   n_rst,
   input  logic                   bit_in,
   input  logic                   start,
   input  logic                   out_ready,
   output logic [WINDOW_BITS:0]   value,
   output logic                   out_valid,
   output logic                   busy
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_COUNT  = 2'd2;
   localparam logic [1:0] ST_HOLD   = 2'd3;

   // With no settle period a measurement starts sampling on the very next edge.
   localparam logic [1:0] ST_FIRST = (SKIP > 0) ? ST_SETTLE : ST_COUNT;

   // Skip counter must be able to hold the value SKIP (it increments on every
   // settle edge, including the last one); keep at least one bit for SKIP=0.
   localparam int                SKIP_W      = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
   localparam logic [SKIP_W-1:0] SKIP_LAST   = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
   localparam logic [WINDOW_BITS-1:0] SAMPLE_LAST = '1;

   logic [1:0]             r_state;
   logic [SKIP_W-1:0]      r_skip_cnt;
   logic [WINDOW_BITS-1:0] r_sample_cnt;
   logic [WINDOW_BITS:0]   r_acc;
   logic [WINDOW_BITS:0]   r_value;
   logic                   r_out_valid;
   logic                   r_busy;

   logic                   w_accept;
   logic [WINDOW_BITS:0]   w_acc_next;

   // A start is only honoured when nothing is in flight: from IDLE, or on the
   // edge that completes the HOLD handshake. Starts during SETTLE/COUNT are
   // dropped, not queued.
   assign w_accept   = start && ((r_state == ST_IDLE) ||
                                 ((r_state == ST_HOLD) && out_ready));

   // The accumulator is one bit wider than the sample counter, so a window of
   // all ones lands exactly on 2^WINDOW_BITS without wrapping.
   assign w_acc_next = r_acc + {{WINDOW_BITS{1'b0}}, bit_in};

   // NOTE: every register here is written with non-blocking assignments so all
   // of them update together from the values present before the edge; blocking
   // assignments would let later lines see half-updated state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         // NOTE: the reset clears every piece of state, including the counters
         // and accumulator, so an aborted window leaves no residue behind.
         r_state      <= ST_IDLE;
         r_skip_cnt   <= '0;
         r_sample_cnt <= '0;
         r_acc        <= '0;
         r_value      <= '0;
         r_out_valid  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Leaving IDLE is handled by the w_accept block below.
            end

            ST_SETTLE: begin
               // bit_in is deliberately ignored while the pipeline flushes.
               r_skip_cnt <= r_skip_cnt + 1'b1;
               if (r_skip_cnt == SKIP_LAST) begin
                  r_state <= ST_COUNT;
               end
            end

            ST_COUNT: begin
               r_acc        <= w_acc_next;
               r_sample_cnt <= r_sample_cnt + 1'b1;   // wraps to 0 on the terminal edge
               if (r_sample_cnt == SAMPLE_LAST) begin
                  // Include the bit on the terminal edge itself.
                  r_value     <= w_acc_next;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
                  r_busy      <= 1'b0;
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase

         // Accepting a start overrides whatever the case above chose, which
         // is how a HOLD handshake with start=1 chains straight into the next
         // measurement. value keeps its last result until the next terminal
         // edge overwrites it.
         if (w_accept) begin
            r_state      <= ST_FIRST;
            r_busy       <= 1'b1;
            r_skip_cnt   <= '0;
            r_sample_cnt <= '0;
            r_acc        <= '0;
         end
      end
   end

   assign value     = r_value;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;

endmodule

// File: tb/tb_stream_decoder.sv
// ---------------------------------------------------------------------------
// tb_stream_decoder
//
// Drives two decoders from the same stimulus: one with SKIP=2 and one with
// SKIP=0, both with a 16-sample window. A transaction-level reference model
// records every bit seen on each clock edge, tracks when each decoder accepts
// a start and when its result is consumed, and pushes the expected count and
// the edge on which out_valid must rise into a per-instance queue. A monitor
// running on the falling edge pops and compares whenever out_valid rises, and
// also checks valid/busy/hold stability every cycle.
// ---------------------------------------------------------------------------
module tb_stream_decoder;

   localparam int WB = 4;
   localparam int N  = 1 << WB;

   logic          clk = 1'b0;
   logic          n_rst;
   logic          bit_in;
   logic          start;
   logic          out_ready;
   logic [WB:0]   value_a, value_b;
   logic          valid_a, valid_b;
   logic          busy_a, busy_b;

   always #5 clk = ~clk;

   stream_decoder #(.WINDOW_BITS(WB), .SKIP(2)) u_dut_a (
      .clk       (clk),
      .n_rst     (n_rst),
      .bit_in    (bit_in),
      .start     (start),
      .out_ready (out_ready),
      .value     (value_a),
      .out_valid (valid_a),
      .busy      (busy_a)
   );

   stream_decoder #(.WINDOW_BITS(WB), .SKIP(0)) u_dut_b (
      .clk       (clk),
      .n_rst     (n_rst),
      .bit_in    (bit_in),
      .start     (start),
      .out_ready (out_ready),
      .value     (value_b),
      .out_valid (valid_b),
      .busy      (busy_b)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef struct {
      int value;
      int edge_i;
   } exp_t;

   exp_t q_a[$];
   exp_t q_b[$];
   bit   hist[0:16383];
   int   edge_n = 0;
   bit   m_act[2];
   int   m_e0[2];

   function automatic int skip_of(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic model_edge(input int i);
      int lat;
      int e;
      int s;
      exp_t x;
      lat = skip_of(i) + N;
      e   = edge_n;
      if (!m_act[i]) begin
         if (start) begin
            m_act[i] = 1'b1;
            m_e0[i]  = e;
         end
      end else if (e == m_e0[i] + lat) begin
         s = 0;
         for (int k = m_e0[i] + skip_of(i) + 1; k <= e; k++) s += int'(hist[k]);
         x.value  = s;
         x.edge_i = e;
         if (i == 0) q_a.push_back(x);
         else        q_b.push_back(x);
      end else if (e > m_e0[i] + lat && out_ready) begin
         if (start) m_e0[i]  = e;
         else       m_act[i] = 1'b0;
      end
   endtask

   initial begin
      m_act[0] = 1'b0;
      m_act[1] = 1'b0;
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) begin
            m_act[0] = 1'b0;
            m_act[1] = 1'b0;
            q_a.delete();
            q_b.delete();
         end else begin
            edge_n++;
            hist[edge_n] = bit_in;
            model_edge(0);
            model_edge(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Monitor
   // ------------------------------------------------------------------------
   bit          mon_en = 1'b0;
   logic        prev_v[2];
   logic [WB:0] prev_val[2];

   task automatic mon_inst(input int i, input logic v, input logic [WB:0] val, input logic bz);
      bit   exp_v;
      bit   have;
      exp_t x;
      exp_v = m_act[i] && (edge_n >= m_e0[i] + skip_of(i) + N);
      check($sformatf("valid[%0d]", i), v, exp_v);
      check($sformatf("busy[%0d]", i), bz, m_act[i]);
      if (v && !prev_v[i]) begin
         have = 1'b0;
         if (i == 0 && q_a.size() > 0) begin x = q_a.pop_front(); have = 1'b1; end
         if (i == 1 && q_b.size() > 0) begin x = q_b.pop_front(); have = 1'b1; end
         check($sformatf("result_pending[%0d]", i), have, 1);
         if (have) begin
            check($sformatf("value[%0d]", i), val, x.value);
            check($sformatf("valid_edge[%0d]", i), edge_n, x.edge_i);
         end
      end else if (v && prev_v[i]) begin
         check($sformatf("hold_stable[%0d]", i), val, prev_val[i]);
      end
      prev_v[i]   = v;
      prev_val[i] = val;
   endtask

   initial begin
      prev_v[0] = 1'b0;
      prev_v[1] = 1'b0;
      prev_val[0] = '0;
      prev_val[1] = '0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            mon_inst(0, valid_a, value_a, busy_a);
            mon_inst(1, valid_b, value_b, busy_b);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic tick();
      @(negedge clk);
   endtask

   // mode 0: ones, 1: zeros, 2: alternating from first sampled edge of the
   // SKIP=2 instance, 3: ones during its settle then zeros, 4: random.
   function automatic bit bitf(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return 1'b0;
         2:       return (k >= 3) && (((k - 3) % 2) == 0);
         3:       return (k <= 2);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Start pulse at E0, then drive the bit for edge E0+k on the falling edge
   // before it. restart_at>0 fires an extra start pulse mid-window.
   task automatic run_window(input int mode, input int restart_at, input string tag);
      bit b;
      int exp_a;
      int exp_b;
      exp_a = 0;
      exp_b = 0;
      tick();
      start  = 1'b1;
      bit_in = bitf(mode, 0);
      for (int k = 1; k <= 2 + N; k++) begin
         tick();
         if (k == 17) begin
            // falling edge after E16: SKIP=0 instance must be valid now
            check({tag, "_b_valid"}, valid_b, 1);
            check({tag, "_b_value"}, value_b, exp_b);
         end
         if (k == 18) check({tag, "_a_not_early"}, valid_a, 0);
         start  = (k == restart_at);
         b      = bitf(mode, k);
         bit_in = b;
         if (k >= 3) exp_a += int'(b);
         if (k <= N) exp_b += int'(b);
      end
      tick();
      start = 1'b0;
      check({tag, "_a_valid"}, valid_a, 1);
      check({tag, "_a_value"}, value_a, exp_a);
      check({tag, "_a_busy"}, busy_a, 1);
   endtask

   task automatic wait_idle(input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 80 && !done; c++) begin
         tick();
         done = !busy_a && !busy_b;
      end
      check({tag, "_idle"}, done, 1);
   endtask

   initial begin
      int last;
      bit pv;

      n_rst     = 1'b1;
      start     = 1'b0;
      bit_in    = 1'b0;
      out_ready = 1'b1;
      #2 n_rst  = 1'b0;
      #1;
      check("rst_value_a", value_a, 0);
      check("rst_valid_a", valid_a, 0);
      check("rst_busy_a",  busy_a,  0);
      check("rst_value_b", value_b, 0);
      check("rst_valid_b", valid_b, 0);
      check("rst_busy_b",  busy_b,  0);
      mon_en = 1'b1;
      tick();
      tick();
      n_rst = 1'b1;

      // Basic patterns with the consumer always ready.
      run_window(0, 0, "ones");
      check("ones_value16", value_a, 16);
      tick();
      check("ones_done_valid", valid_a, 0);
      check("ones_done_busy", busy_a, 0);
      run_window(1, 0, "zeros");
      check("zeros_value0", value_a, 0);
      wait_idle("zeros");
      run_window(2, 0, "alt");
      check("alt_value8", value_a, 8);
      wait_idle("alt");
      run_window(3, 0, "settle");
      check("settle_value0", value_a, 0);
      wait_idle("settle");

      // A start pulse mid-COUNT must not restart the window.
      run_window(0, 8, "midstart");
      check("midstart_value16", value_a, 16);
      wait_idle("midstart");

      // Backpressure: hold for 10 cycles, then accept.
      out_ready = 1'b0;
      run_window(4, 0, "bp");
      repeat (10) tick();
      check("bp_still_valid", valid_a, 1);
      out_ready = 1'b1;
      tick();
      check("bp_released_a", valid_a, 0);
      check("bp_idle_a", busy_a, 0);
      check("bp_released_b", valid_b, 0);
      check("bp_idle_b", busy_b, 0);

      // Back-to-back with start and out_ready held high.
      bit_in = 1'b1;
      start  = 1'b1;
      last   = -1;
      pv     = 1'b0;
      for (int c = 0; c < 19 * 4; c++) begin
         tick();
         if (valid_a && !pv) begin
            check("b2b_value", value_a, 16);
            if (last >= 0) check("b2b_spacing", c - last, 19);
            last = c;
         end
         pv = valid_a;
      end
      start = 1'b0;
      wait_idle("b2b");

      // Reset asserted between edges after the 7th sample.
      tick();
      start  = 1'b1;
      bit_in = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         start = 1'b0;
      end
      #2 n_rst = 1'b0;
      #1;
      check("midrst_value_a", value_a, 0);
      check("midrst_valid_a", valid_a, 0);
      check("midrst_busy_a",  busy_a,  0);
      check("midrst_busy_b",  busy_b,  0);
      tick();
      tick();
      n_rst = 1'b1;
      run_window(0, 0, "fresh");
      check("fresh_value16", value_a, 16);
      wait_idle("fresh");

      // Randomized traffic.
      for (int c = 0; c < 1500; c++) begin
         tick();
         bit_in    = 1'($urandom_range(0, 1));
         start     = ($urandom_range(0, 5) == 0);
         out_ready = ($urandom_range(0, 2) != 0);
      end
      start     = 1'b0;
      out_ready = 1'b1;
      wait_idle("rand");
      tick();
      check("queue_a_drained", q_a.size(), 0);
      check("queue_b_drained", q_b.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
